// File: rtl/wb_arb_pkg.sv
// Shared configuration and types for the register-file write arbiter.
// RW / REGNO / REGNO_LOG defaults live here and nowhere else.
package wb_arb_pkg;

    localparam int unsigned CFG_RW        = 16;
    localparam int unsigned CFG_REGNO     = 8;
    localparam int unsigned CFG_REGNO_LOG = 3;

    // EMPTY: skid buffer free; HELD: one execute result parked behind a memory write
    typedef enum logic {
        StEmpty,
        StHeld
    } arb_state_e;

endpackage

// File: rtl/wb_arb_en_reg.sv
// Enable register cell with asynchronous active-high reset to zero.
module en_reg #(
    parameter int unsigned W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/wb_arb_onehot_dec.sv
// Index to one-hot decoder with an enable; output is all-zero when disabled.
module onehot_dec #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic         i_en,
    input  logic [W-1:0] i_idx,
    output logic [N-1:0] o_oh
);

    always_comb begin
        o_oh = '0;
        for (int i = 0; i < N; i++) begin
            o_oh[i] = i_en && (i_idx == W'(i));
        end
    end

endmodule

// File: rtl/wb_arb.sv
// Register-file write arbiter: memory load results win over execute results, which
// park in a one-entry skid buffer on collision. Also tracks outstanding loads.
module wb_arb
    import wb_arb_pkg::*;
#(
    parameter int unsigned RW        = CFG_RW,
    parameter int unsigned REGNO     = CFG_REGNO,
    parameter int unsigned REGNO_LOG = CFG_REGNO_LOG
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ex_valid,
    output logic                 o_ex_ready,
    input  logic [REGNO_LOG-1:0] i_ex_rd,
    input  logic [RW-1:0]        i_ex_d,
    input  logic                 i_ld_issue,
    input  logic [REGNO_LOG-1:0] i_ld_rd,
    input  logic                 i_mem_valid,
    input  logic [REGNO_LOG-1:0] i_mem_rd,
    input  logic [RW-1:0]        i_mem_d,
    output logic                 o_gie,
    output logic [REGNO-1:0]     o_ie,
    output logic [RW-1:0]        o_d,
    output logic [REGNO-1:0]     o_busy,
    output logic                 o_err
);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic                   w_accept;
    logic                   w_hold_load;
    logic                   w_sel_valid;
    logic [REGNO_LOG-1:0]   w_sel_rd;
    logic [RW-1:0]          w_sel_d;
    logic [REGNO_LOG-1:0]   r_hold_rd;
    logic [RW-1:0]          r_hold_d;
    logic [REGNO-1:0]       w_sel_oh;
    logic [REGNO-1:0]       w_set_oh;
    logic [REGNO-1:0]       w_clr_oh;
    logic [REGNO-1:0]       r_busy;
    logic [REGNO-1:0]       w_busy_d;
    logic                   r_err;
    logic                   w_err_d;

    // Ready depends only on the skid state, never on i_mem_valid
    assign o_ex_ready = (r_state == StEmpty);
    assign w_accept   = i_ex_valid && o_ex_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StEmpty: if (w_accept && i_mem_valid) w_state_nxt = StHeld;
            StHeld:  if (!i_mem_valid)            w_state_nxt = StEmpty;
            default: w_state_nxt = StEmpty;
        endcase
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rd    = i_ex_rd;
        w_sel_d     = i_ex_d;
        w_hold_load = 1'b0;
        if (i_mem_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = i_mem_rd;
            w_sel_d     = i_mem_d;
            w_hold_load = w_accept;
        end else if (r_state == StHeld) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = r_hold_rd;
            w_sel_d     = r_hold_d;
        end else if (w_accept) begin
            w_sel_valid = 1'b1;
        end
    end

    en_reg #(.W(REGNO_LOG + RW)) u_hold (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_hold_load),
        .i_d   ({i_ex_rd, i_ex_d}),
        .o_q   ({r_hold_rd, r_hold_d})
    );

    onehot_dec #(.N(REGNO), .W(REGNO_LOG)) u_dec_wr (
        .i_en  (w_sel_valid),
        .i_idx (w_sel_rd),
        .o_oh  (w_sel_oh)
    );

    onehot_dec #(.N(REGNO), .W(REGNO_LOG)) u_dec_set (
        .i_en  (i_ld_issue),
        .i_idx (i_ld_rd),
        .o_oh  (w_set_oh)
    );

    onehot_dec #(.N(REGNO), .W(REGNO_LOG)) u_dec_clr (
        .i_en  (i_mem_valid),
        .i_idx (i_mem_rd),
        .o_oh  (w_clr_oh)
    );

    en_reg #(.W(1)) u_gie (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (1'b1),
        .i_d   (w_sel_valid),
        .o_q   (o_gie)
    );

    en_reg #(.W(REGNO)) u_ie (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (1'b1),
        .i_d   (w_sel_oh),
        .o_q   (o_ie)
    );

    en_reg #(.W(RW)) u_d (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_sel_valid),
        .i_d   (w_sel_d),
        .o_q   (o_d)
    );

    // Set wins over clear so a same-cycle return/reissue keeps the register pending
    assign w_busy_d = (r_busy & ~w_clr_oh) | w_set_oh;
    assign w_err_d  = r_err || (i_mem_valid && ((r_busy & w_clr_oh) == '0));

    en_reg #(.W(REGNO)) u_busy (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (1'b1),
        .i_d   (w_busy_d),
        .o_q   (r_busy)
    );

    en_reg #(.W(1)) u_err (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (1'b1),
        .i_d   (w_err_d),
        .o_q   (r_err)
    );

    assign o_busy = r_busy;
    assign o_err  = r_err;

endmodule

// File: tb/tb_wb_arb.sv
// Self-checking bench for wb_arb: vector table feeding a write scoreboard queue,
// followed by a hand-written mid-HELD reset sequence.
module tb_wb_arb;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_rd;
    logic [15:0] ex_d;
    logic        ld_issue;
    logic [2:0]  ld_rd;
    logic        mem_valid;
    logic [2:0]  mem_rd;
    logic [15:0] mem_d;
    logic        gie;
    logic [7:0]  ie;
    logic [15:0] d;
    logic [7:0]  busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        ex_v;
        logic [2:0]  ex_rd;
        logic [15:0] ex_d;
        logic        ld;
        logic [2:0]  ld_rd;
        logic        mem_v;
        logic [2:0]  mem_rd;
        logic [15:0] mem_d;
        logic        rdy;
        logic        gie;
        logic [7:0]  ie;
        logic [15:0] d;
        logic [7:0]  busy;
        logic        err;
    } vec_t;

    typedef struct {
        logic        gie;
        logic [7:0]  ie;
        logic [15:0] d;
    } wr_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];
    wr_t  sb_q[$];

    wb_arb dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ex_valid  (ex_valid),
        .o_ex_ready  (ex_ready),
        .i_ex_rd     (ex_rd),
        .i_ex_d      (ex_d),
        .i_ld_issue  (ld_issue),
        .i_ld_rd     (ld_rd),
        .i_mem_valid (mem_valid),
        .i_mem_rd    (mem_rd),
        .i_mem_d     (mem_d),
        .o_gie       (gie),
        .o_ie        (ie),
        .o_d         (d),
        .o_busy      (busy),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic exv, logic [2:0] exr, logic [15:0] exd,
                                logic ld, logic [2:0] ldr,
                                logic mv, logic [2:0] mr, logic [15:0] md,
                                logic rdy, logic g, logic [7:0] e, logic [15:0] dd,
                                logic [7:0] b, logic er);
        vec_t v;
        v.ex_v = exv;  v.ex_rd = exr;  v.ex_d = exd;
        v.ld = ld;     v.ld_rd = ldr;
        v.mem_v = mv;  v.mem_rd = mr;  v.mem_d = md;
        v.rdy = rdy;   v.gie = g;      v.ie = e;    v.d = dd;
        v.busy = b;    v.err = er;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0; ex_rd = '0; ex_d = '0;
        ld_issue = 1'b0; ld_rd = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_d = '0;
    endtask

    task automatic pop_check(string tag);
        wr_t w;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s sb_empty: got 0x0, want 0x1", tag);
            return;
        end
        w = sb_q.pop_front();
        chk({tag, " gie"}, 32'(gie), 32'(w.gie));
        chk({tag, " ie"}, 32'(ie), 32'(w.ie));
        if (w.gie) chk({tag, " d"}, 32'(d), 32'(w.d));
    endtask

    task automatic apply(int i, vec_t v);
        string tag;
        wr_t   w;
        tag = $sformatf("v%0d", i);
        @(negedge clk);
        ex_valid = v.ex_v; ex_rd = v.ex_rd; ex_d = v.ex_d;
        ld_issue = v.ld;   ld_rd = v.ld_rd;
        mem_valid = v.mem_v; mem_rd = v.mem_rd; mem_d = v.mem_d;
        #1;
        chk({tag, " ready"}, 32'(ex_ready), 32'(v.rdy));
        w.gie = v.gie; w.ie = v.ie; w.d = v.d;
        sb_q.push_back(w);
        @(posedge clk);
        #1;
        pop_check(tag);
        chk({tag, " busy"}, 32'(busy), 32'(v.busy));
        chk({tag, " err"}, 32'(err), 32'(v.err));
    endtask

    task automatic idle_cycle(string tag);
        wr_t w;
        @(negedge clk);
        drive_idle();
        w.gie = 1'b0; w.ie = '0; w.d = '0;
        sb_q.push_back(w);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        //            exv exrd exd      ld ldr mv mrd md       rdy gie ie     d        busy   err
        vecs[0]  = mk(1, 3, 16'h1234, 0, 0, 0, 0, 16'h0000, 1, 1, 8'h08, 16'h1234, 8'h00, 0);
        vecs[1]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 8'h00, 16'h0000, 8'h00, 0);
        vecs[2]  = mk(0, 0, 16'h0000, 1, 6, 0, 0, 16'h0000, 1, 0, 8'h00, 16'h0000, 8'h40, 0);
        vecs[3]  = mk(0, 0, 16'h0000, 1, 6, 1, 6, 16'h0606, 1, 1, 8'h40, 16'h0606, 8'h40, 0);
        vecs[4]  = mk(0, 0, 16'h0000, 0, 0, 1, 6, 16'h0660, 1, 1, 8'h40, 16'h0660, 8'h00, 0);
        vecs[5]  = mk(0, 0, 16'h0000, 1, 5, 0, 0, 16'h0000, 1, 0, 8'h00, 16'h0000, 8'h20, 0);
        vecs[6]  = mk(1, 2, 16'hAAAA, 0, 0, 1, 5, 16'h5555, 1, 1, 8'h20, 16'h5555, 8'h00, 0);
        vecs[7]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 8'h04, 16'hAAAA, 8'h00, 0);
        vecs[8]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 8'h00, 16'h0000, 8'h00, 0);
        vecs[9]  = mk(0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 0, 8'h00, 16'h0000, 8'h01, 0);
        vecs[10] = mk(0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 1, 0, 8'h00, 16'h0000, 8'h03, 0);
        vecs[11] = mk(0, 0, 16'h0000, 1, 4, 0, 0, 16'h0000, 1, 0, 8'h00, 16'h0000, 8'h13, 0);
        vecs[12] = mk(0, 0, 16'h0000, 1, 7, 0, 0, 16'h0000, 1, 0, 8'h00, 16'h0000, 8'h93, 0);
        vecs[13] = mk(1, 3, 16'h3333, 0, 0, 1, 0, 16'h1000, 1, 1, 8'h01, 16'h1000, 8'h92, 0);
        vecs[14] = mk(1, 5, 16'hBAD0, 0, 0, 1, 1, 16'h1001, 0, 1, 8'h02, 16'h1001, 8'h90, 0);
        vecs[15] = mk(1, 5, 16'hBAD0, 0, 0, 1, 4, 16'h1004, 0, 1, 8'h10, 16'h1004, 8'h80, 0);
        vecs[16] = mk(1, 5, 16'hBAD0, 0, 0, 1, 7, 16'h1007, 0, 1, 8'h80, 16'h1007, 8'h00, 0);
        vecs[17] = mk(1, 5, 16'hBAD0, 0, 0, 0, 0, 16'h0000, 0, 1, 8'h08, 16'h3333, 8'h00, 0);
        vecs[18] = mk(1, 5, 16'hBAD0, 0, 0, 0, 0, 16'h0000, 1, 1, 8'h20, 16'hBAD0, 8'h00, 0);
        vecs[19] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 8'h00, 16'h0000, 8'h00, 0);
        vecs[20] = mk(0, 0, 16'h0000, 0, 0, 1, 1, 16'h0101, 1, 1, 8'h02, 16'h0101, 8'h00, 1);
        vecs[21] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 8'h00, 16'h0000, 8'h00, 1);

        rst = 1'b1;
        drive_idle();
        #3;
        chk("rst gie", 32'(gie), 32'h0);
        chk("rst ie", 32'(ie), 32'h0);
        chk("rst d", 32'(d), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst err", 32'(err), 32'h0);
        chk("rst ready", 32'(ex_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply(i, vecs[i]);
        end

        // Enter HELD with a load pending, then reset between edges
        begin
            wr_t w;
            @(negedge clk);
            ex_valid = 1'b1; ex_rd = 3'd4; ex_d = 16'h4444;
            ld_issue = 1'b1; ld_rd = 3'd3;
            mem_valid = 1'b1; mem_rd = 3'd2; mem_d = 16'h2222;
            w.gie = 1'b1; w.ie = 8'h04; w.d = 16'h2222;
            sb_q.push_back(w);
            @(posedge clk);
            #1;
            pop_check("held");
            chk("held busy", 32'(busy), 32'h08);
            chk("held ready", 32'(ex_ready), 32'h0);
        end
        #2;
        drive_idle();
        ex_valid = 1'b1; ex_rd = 3'd7; ex_d = 16'h7777;
        rst = 1'b1;
        #1;
        chk("arst gie", 32'(gie), 32'h0);
        chk("arst ie", 32'(ie), 32'h0);
        chk("arst d", 32'(d), 32'h0);
        chk("arst busy", 32'(busy), 32'h0);
        chk("arst err", 32'(err), 32'h0);
        chk("arst ready", 32'(ex_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("inrst gie", 32'(gie), 32'h0);
        chk("inrst ready", 32'(ex_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            idle_cycle($sformatf("post_rst%0d", i));
        end
        chk("post_rst err", 32'(err), 32'h0);
        chk("post_rst busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 Parameter RW, default `RW (16), register data width.
REQ-002 Parameter REGNO, default `REGNO (8), number of architectural registers.
REQ-003 Parameter REGNO_LOG, default `REGNO_LOG (3), register index width.
REQ-004 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_ex_valid  in  1  execute stage offers an ALU result.
REQ-007 o_ex_ready  out  1  arbiter accepts the execute result this cycle.
REQ-008 i_ex_rd  in  REGNO_LOG  execute destination register.
REQ-009 i_ex_d  in  RW  execute result data.
REQ-010 i_ld_issue  in  1  a load leaves execute toward memory; marks destination pending.
REQ-011 i_ld_rd  in  REGNO_LOG  destination of the issued load.
REQ-012 i_mem_valid  in  1  load data returns; no backpressure, must be taken this cycle.
REQ-013 i_mem_rd  in  REGNO_LOG  load destination register.
REQ-014 i_mem_d  in  RW  load data.
REQ-015 o_gie  out  1  register-file global write enable.
REQ-016 o_ie  out  REGNO  one-hot register write select.
REQ-017 o_d  out  RW  register-file write data.
REQ-018 o_busy  out  REGNO  scoreboard, bit i set while a load to register i is outstanding.
REQ-019 o_err  out  1  sticky flag, load returned to a register not marked pending.

Function
REQ-020 Arbiter SHALL present at most one register write per cycle; o_ie SHALL be zero or one-hot, never multi-hot.
REQ-021 Write priority SHALL be: memory result > held execute entry > new execute result.
REQ-022 o_gie/o_ie/o_d SHALL be registered: a write selected in cycle N appears on outputs in cycle N+1 only, and o_gie is 0 in any cycle following no selection.
REQ-023 o_ex_ready SHALL equal NOT hold_valid (one-entry skid buffer), combinationally independent of i_mem_valid.
REQ-024 States: EMPTY (hold_valid=0), HELD (hold_valid=1).
REQ-025 EMPTY, ex accepted, i_mem_valid=0: ex result written; stay EMPTY.
REQ-026 EMPTY, ex accepted, i_mem_valid=1: memory written; ex rd/data captured into hold; go HELD.
REQ-027 HELD, i_mem_valid=1: memory written; hold kept; stay HELD (any number of cycles).
REQ-028 HELD, i_mem_valid=0: hold written; go EMPTY; new ex result not accepted this cycle (ready was 0).
REQ-029 Scoreboard: i_ld_issue sets o_busy[i_ld_rd]; i_mem_valid clears o_busy[i_mem_rd]; both same index same cycle -> bit ends set.
REQ-030 i_mem_valid with o_busy[i_mem_rd]=0 SHALL still perform the write and SHALL set o_err until reset.
REQ-031 o_busy SHALL update on the clock edge (visible cycle after issue/return); upstream hazard stalling is the execute stage's duty, not this block's.
REQ-032 All REGNO registers, including r0, SHALL be writable; no index is hardwired.

Reset
REQ-033 On i_rst assertion, immediately and without clock: o_gie=0, o_ie=0, o_d=0, o_busy=0, o_err=0, hold_valid=0 (EMPTY), hold contents discarded.
REQ-034 Reset mid-operation SHALL drop any held or in-flight write; no write appears after reset deassertion unless newly offered.
REQ-035 While i_rst is high o_ex_ready SHALL be 1 but no acceptance takes effect.

Structure
REQ-036 RW, REGNO, REGNO_LOG SHALL come from the shared config include; no local redefinition.
REQ-037 Index-to-one-hot decode SHALL be a single sub-module named onehot_dec, used for o_ie and scoreboard set/clear masks.
REQ-038 Hold buffer and output registers SHALL reuse the codebase's enable-register cell where an enable/reset register fits, with async reset variant.

Verification
REQ-039 Ex only: ex_valid=1 rd=3 d=0x1234 -> next cycle o_gie=1, o_ie=0x08, o_d=0x1234; ready stays 1.
REQ-040 Collision: ex rd=2 d=0xAAAA and mem rd=5 d=0x5555 same cycle -> cycle+1 o_ie=0x20 d=0x5555, ready=0; cycle+2 o_ie=0x04 d=0xAAAA; cycle+3 ready=1.
REQ-041 Starvation: HELD with mem_valid for 4 consecutive cycles -> 4 memory writes, hold written on 5th output cycle, no ex result lost or duplicated.
REQ-042 Scoreboard: ld_issue rd=6 -> o_busy=0x40; mem return rd=6 with simultaneous ld_issue rd=6 -> o_busy stays 0x40; later return rd=6 -> 0x00, o_err=0.
REQ-043 Error/reset: mem return rd=1 with o_busy=0 -> write occurs, o_err=1 sticky; assert i_rst mid-HELD between clock edges -> all outputs 0 at once, held entry never written.
